// File: rtl/transport_send_if.sv
// Session/network handshake bundle for the transport-layer transmit block.
// The session side and the network side share one interface instance; the
// slave modport is what transport_send sees, the master modport is its peer.
interface transport_send_if;
    logic        cmdValid;
    logic [15:0] cmdData;
    logic        cmdReady;
    logic        audioValid;
    logic [15:0] audioData;
    logic        audioReady;
    logic        audioDrop;
    logic        networkBusy;
    logic        sendSignal;
    logic [7:0]  packetOut;
    logic        txBusy;

    modport slave (
        input  cmdValid, cmdData, audioValid, audioData, networkBusy,
        output cmdReady, audioReady, audioDrop, sendSignal, packetOut, txBusy
    );

    modport master (
        output cmdValid, cmdData, audioValid, audioData, networkBusy,
        input  cmdReady, audioReady, audioDrop, sendSignal, packetOut, txBusy
    );
endinterface

// File: rtl/transport_send.sv
// Transport-layer transmit side. Holds one session control word and a FIFO of
// audio samples, and serialises them into fixed-length byte packets:
//   control: 0x40, word hi, word lo, zero padding
//   audio  : 0x80, NSAMP words (hi then lo), zero padding
// One byte leaves per cycle while the network is not busy; a busy cycle
// freezes the whole packet engine. Control packets win over audio when the
// engine is idle, but a packet in flight is never interrupted.
module transport_send #(
    parameter int packetSize = 127,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    transport_send_if.slave bus
);

    localparam int PBYTES = (packetSize + 1) / 8;
    localparam int NSAMP  = (PBYTES - 1) / 2;
    localparam int CW     = $clog2(PBYTES + 1);
    localparam int WCW    = $clog2(NSAMP + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0]  C_LAST      = CW'(PBYTES - 1);
    localparam logic [CW-1:0]  C_B_ONE     = CW'(1);
    localparam logic [WCW-1:0] C_W_LAST    = WCW'(NSAMP - 1);
    localparam logic [WCW-1:0] C_W_ONE     = WCW'(1);
    localparam logic [AW-1:0]  C_PTR_ONE   = AW'(1);
    localparam logic [AW:0]    C_CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]    C_DEPTH     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]    C_NSAMP_CNT = (AW + 1)'(NSAMP);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_CMD_HI = 3'd2,
        S_CMD_LO = 3'd3,
        S_AUD_HI = 3'd4,
        S_AUD_LO = 3'd5,
        S_PAD    = 3'd6
    } state_t;

    // command slot
    logic        r_cmd_ready;
    logic [15:0] r_cmd_word;

    // audio FIFO
    logic [15:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          r_audio_ready;
    logic          r_audio_drop;

    // packet engine
    state_t        r_state;
    logic          r_send;
    logic [7:0]    r_pkt;
    logic          r_txbusy;
    logic [CW-1:0] r_bcnt;
    logic [WCW-1:0] r_wcnt;
    logic          r_is_cmd;
    logic [15:0]   r_word;

    logic          w_push;
    logic          w_pop;
    logic          w_cmd_done;
    logic [15:0]   w_head;
    logic [AW:0]   w_count_nxt;
    state_t        w_tail_state;

    assign w_push     = bus.audioValid & r_audio_ready;
    assign w_pop      = (r_state == S_AUD_HI) & ~bus.networkBusy;
    assign w_cmd_done = (r_state == S_CMD_LO) & ~bus.networkBusy;
    assign w_head     = r_mem[r_rd];

    // After the last payload byte: pad if bytes remain, otherwise go idle.
    assign w_tail_state = (r_bcnt == C_LAST) ? S_IDLE : S_PAD;

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_CNT_ONE;
            2'b01:   w_count_nxt = r_count - C_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Single-word command slot: filled on handshake, freed once its low byte leaves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_ready <= 1'b1;
            r_cmd_word  <= 16'h0000;
        end else if (w_cmd_done) begin
            r_cmd_ready <= 1'b1;
        end else if (bus.cmdValid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_cmd_word  <= bus.cmdData;
        end else begin
            r_cmd_ready <= r_cmd_ready;
        end
    end

    // Sample storage; only written on an accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= bus.audioData;
        end
    end

    // FIFO pointers, occupancy, registered ready and overflow-drop pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr          <= '0;
            r_rd          <= '0;
            r_count       <= '0;
            r_audio_ready <= 1'b1;
            r_audio_drop  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd <= r_rd + C_PTR_ONE;
            end
            r_count       <= w_count_nxt;
            r_audio_ready <= (w_count_nxt != C_DEPTH);
            r_audio_drop  <= bus.audioValid & ~r_audio_ready;
        end
    end

    // Packet engine: picks the next packet in IDLE, then emits one byte per
    // non-busy cycle; a busy cycle freezes state, counters and the output byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_send   <= 1'b0;
            r_pkt    <= 8'h00;
            r_txbusy <= 1'b0;
            r_bcnt   <= '0;
            r_wcnt   <= '0;
            r_is_cmd <= 1'b0;
            r_word   <= 16'h0000;
        end else if (r_state == S_IDLE) begin
            r_send   <= 1'b0;
            r_txbusy <= 1'b0;
            r_bcnt   <= '0;
            r_wcnt   <= '0;
            if (!r_cmd_ready) begin
                r_is_cmd <= 1'b1;
                r_state  <= S_HDR;
            end else if (r_count >= C_NSAMP_CNT) begin
                r_is_cmd <= 1'b0;
                r_state  <= S_HDR;
            end else begin
                r_state  <= S_IDLE;
            end
        end else if (bus.networkBusy) begin
            r_send <= 1'b0;
        end else begin
            r_send <= 1'b1;
            r_bcnt <= r_bcnt + C_B_ONE;
            case (r_state)
                S_HDR: begin
                    r_pkt    <= r_is_cmd ? 8'h40 : 8'h80;
                    r_txbusy <= 1'b1;
                    r_state  <= r_is_cmd ? S_CMD_HI : S_AUD_HI;
                end
                S_CMD_HI: begin
                    r_pkt   <= r_cmd_word[15:8];
                    r_state <= S_CMD_LO;
                end
                S_CMD_LO: begin
                    r_pkt   <= r_cmd_word[7:0];
                    r_state <= w_tail_state;
                end
                S_AUD_HI: begin
                    r_pkt   <= w_head[15:8];
                    r_word  <= w_head;
                    r_state <= S_AUD_LO;
                end
                S_AUD_LO: begin
                    r_pkt  <= r_word[7:0];
                    r_wcnt <= r_wcnt + C_W_ONE;
                    if (r_wcnt == C_W_LAST) begin
                        r_state <= w_tail_state;
                    end else begin
                        r_state <= S_AUD_HI;
                    end
                end
                S_PAD: begin
                    r_pkt <= 8'h00;
                    if (r_bcnt == C_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_PAD;
                    end
                end
                default: begin
                    r_send  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmdReady   = r_cmd_ready;
    assign bus.audioReady = r_audio_ready;
    assign bus.audioDrop  = r_audio_drop;
    assign bus.sendSignal = r_send;
    assign bus.packetOut  = r_pkt;
    assign bus.txBusy     = r_txbusy;

endmodule

// File: tb/tb_transport_send.sv
// Bench for transport_send: directed scenarios followed by a randomized phase.
// Drivers push expected packets into per-stream queues when they issue
// stimulus; a negedge monitor assembles 16-byte packets and scores them.
module tb_transport_send;

    logic clk;
    logic rst_n;
    logic busy_dir;
    logic rand_en;

    transport_send_if bus ();

    transport_send #(.packetSize(127), .FIFO_DEPTH(16)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [127:0] exp_cmd [$];
    logic [127:0] exp_aud [$];
    logic [15:0]  pend [$];
    logic [7:0]   hdr_log [$];

    logic [127:0] cur_pkt;
    int cur_len   = 0;
    int cyc       = 0;
    int first_t   = 0;
    int last_span = 0;
    int n_strobe  = 0;
    int stall_bad = 0;
    int gap_bad   = 0;
    int txb_bad   = 0;
    logic busy_prev = 1'b0;
    logic gap_pending = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // networkBusy driver: random in the random phase, directed otherwise
    always @(posedge clk) begin
        #2;
        bus.networkBusy = rand_en ? ($urandom_range(0, 3) == 0) : busy_dir;
    end

    // monitor: assemble packets, score them, watch stall/gap/txBusy rules
    always @(negedge clk) begin
        logic [127:0] e;
        cyc++;
        if (!rst_n) begin
            cur_len = 0;
            gap_pending = 1'b0;
        end else begin
            if (gap_pending && bus.sendSignal) gap_bad++;
            gap_pending = 1'b0;
            if (bus.sendSignal) begin
                n_strobe++;
                if (!bus.txBusy) txb_bad++;
                if (busy_prev === 1'b1) stall_bad++;
                if (cur_len == 0) first_t = cyc;
                cur_pkt = {cur_pkt[119:0], bus.packetOut};
                cur_len++;
                if (cur_len == 16) begin
                    last_span = cyc - first_t;
                    hdr_log.push_back(cur_pkt[127:120]);
                    if (cur_pkt[127:120] == 8'h40) begin
                        if (exp_cmd.size() == 0) chk("cmd_pkt_unexpected", cur_pkt, 128'h0);
                        else begin e = exp_cmd.pop_front(); chk("cmd_pkt", cur_pkt, e); end
                    end else if (cur_pkt[127:120] == 8'h80) begin
                        if (exp_aud.size() == 0) chk("aud_pkt_unexpected", cur_pkt, 128'h0);
                        else begin e = exp_aud.pop_front(); chk("aud_pkt", cur_pkt, e); end
                    end else begin
                        chk("pkt_header", {120'h0, cur_pkt[127:120]}, 128'h40);
                    end
                    cur_len = 0;
                    gap_pending = 1'b1;
                end
            end
        end
        busy_prev = bus.networkBusy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] cmd_pkt(input logic [15:0] d);
        return {8'h40, d, 104'h0};
    endfunction

    task automatic model_sample(input logic [15:0] d);
        logic [127:0] p;
        pend.push_back(d);
        if (pend.size() == 7) begin
            p = 128'h0;
            p[127:120] = 8'h80;
            for (int i = 0; i < 7; i++) p[119 - 16*i -: 16] = pend[i];
            exp_aud.push_back(p);
            pend.delete();
        end
    endtask

    task automatic send_cmd(input logic [15:0] d);
        int t = 0;
        while (!bus.cmdReady && t < 500) begin tick(); t++; end
        if (t >= 500) chk("cmd_ready_timeout", 128'h0, 128'h1);
        bus.cmdValid = 1'b1;
        bus.cmdData  = d;
        exp_cmd.push_back(cmd_pkt(d));
        tick();
        bus.cmdValid = 1'b0;
    endtask

    task automatic push_sample(input logic [15:0] d);
        int t = 0;
        while (!bus.audioReady && t < 500) begin tick(); t++; end
        if (t >= 500) chk("audio_ready_timeout", 128'h0, 128'h1);
        bus.audioValid = 1'b1;
        bus.audioData  = d;
        model_sample(d);
        tick();
        bus.audioValid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_cmd.size() != 0 || exp_aud.size() != 0 || cur_len != 0) && t < 3000) begin
            tick(); t++;
        end
        if (t >= 3000) chk("drain_timeout", 128'h0, 128'h1);
        repeat (3) tick();
    endtask

    task automatic count_strobes(input int n);
        int k = 0;
        int t = 0;
        while (k < n && t < 500) begin
            tick(); t++;
            if (bus.sendSignal) k++;
        end
        if (t >= 500) chk("strobe_timeout", 128'h0, 128'h1);
    endtask

    initial begin
        int s0;
        logic [15:0] d;
        rst_n = 1'b0;
        busy_dir = 1'b0;
        rand_en = 1'b0;
        bus.cmdValid = 1'b0;
        bus.cmdData = 16'h0;
        bus.audioValid = 1'b0;
        bus.audioData = 16'h0;

        // reset values
        repeat (3) tick();
        chk("rst_send_pkt", {127'h0, bus.sendSignal}, 128'h0);
        chk("rst_packetOut", {120'h0, bus.packetOut}, 128'h0);
        chk("rst_flags", {124'h0, bus.txBusy, bus.audioDrop, bus.cmdReady, bus.audioReady}, 128'h3);
        rst_n = 1'b1;
        repeat (3) tick();

        // case 1: one command, latency and byte order
        chk("t1_cmdReady_idle", {127'h0, bus.cmdReady}, 128'h1);
        bus.cmdValid = 1'b1;
        bus.cmdData = 16'h1234;
        exp_cmd.push_back(cmd_pkt(16'h1234));
        tick();
        bus.cmdValid = 1'b0;
        chk("t1_cmdReady_held", {127'h0, bus.cmdReady}, 128'h0);
        tick();
        chk("t1_no_early_strobe", {127'h0, bus.sendSignal}, 128'h0);
        tick();
        chk("t1_hdr_latency", {119'h0, bus.sendSignal, bus.packetOut}, {119'h0, 1'b1, 8'h40});
        tick();
        chk("t1_cmdReady_mid", {127'h0, bus.cmdReady}, 128'h0);
        drain();
        chk("t1_span", last_span, 128'd15);
        chk("t1_cmdReady_after", {127'h0, bus.cmdReady}, 128'h1);

        // case 2: samples 1..7, FIFO empty afterwards
        for (int i = 1; i <= 7; i++) push_sample(16'(i));
        drain();
        s0 = n_strobe;
        repeat (30) tick();
        chk("t2_no_extra_pkt", n_strobe, s0);
        chk("t2_audioReady", {127'h0, bus.audioReady}, 128'h1);

        // case 3: 5-cycle stall after byte 4
        send_cmd(16'h1234);
        count_strobes(4);
        busy_dir = 1'b1;
        repeat (5) tick();
        busy_dir = 1'b0;
        drain();
        chk("t3_span", last_span, 128'd20);

        // case 4: command arriving during an audio packet, 14 samples queued
        busy_dir = 1'b1;
        tick();
        hdr_log.delete();
        for (int i = 1; i <= 14; i++) push_sample(16'h0A00 + 16'(i));
        busy_dir = 1'b0;
        count_strobes(3);
        send_cmd(16'hBEEF);
        drain();
        chk("t4_pkt_count", hdr_log.size(), 128'd3);
        if (hdr_log.size() >= 3)
            chk("t4_order", {104'h0, hdr_log[0], hdr_log[1], hdr_log[2]}, {104'h0, 24'h804080});

        // case 5: FIFO full, drop of the 17th sample
        busy_dir = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) push_sample(16'h5000 + 16'(i));
        chk("t5_full_ready", {127'h0, bus.audioReady}, 128'h0);
        bus.audioValid = 1'b1;
        bus.audioData = 16'hDEAD;
        tick();
        bus.audioValid = 1'b0;
        chk("t5_drop_pulse", {127'h0, bus.audioDrop}, 128'h1);
        tick();
        chk("t5_drop_end", {127'h0, bus.audioDrop}, 128'h0);
        busy_dir = 1'b0;
        for (int i = 17; i <= 21; i++) push_sample(16'h5000 + 16'(i));
        drain();

        // case 6: reset in the middle of an audio packet
        for (int i = 1; i <= 7; i++) push_sample(16'h6000 + 16'(i));
        count_strobes(6);
        rst_n = 1'b0;
        #1;
        chk("t6_send_now", {127'h0, bus.sendSignal}, 128'h0);
        chk("t6_outputs", {116'h0, bus.packetOut, bus.txBusy, bus.audioDrop, bus.cmdReady, bus.audioReady},
            {116'h0, 8'h00, 4'b0011});
        exp_aud.delete();
        pend.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        s0 = n_strobe;
        repeat (40) tick();
        chk("t6_silent_after", n_strobe, s0);

        // randomized mix with random network stalls
        rand_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) send_cmd(d);
            else push_sample(d);
            repeat ($urandom_range(0, 2)) tick();
        end
        while (pend.size() != 0) push_sample(16'($urandom));
        rand_en = 1'b0;
        repeat (2) tick();
        drain();

        chk("stall_strobes", stall_bad, 128'h0);
        chk("packet_gap", gap_bad, 128'h0);
        chk("txbusy_low_on_strobe", txb_bad, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
